// File: rtl/ups_xadc_drp_ctrl.sv
// XADC DRP sequencer: writes the config table after reset, then arbitrates the DRP port (EOC sample reads first, host second).
// Latency: den one cycle after a pending sample or host grant; result one cycle after drdy. Host holds req until ack; one sample slot, overwrite flagged.
module ups_xadc_drp_ctrl #(
    parameter logic [15:0] CFG_REG0 = 16'h0011,
    parameter logic [15:0] CFG_REG1 = 16'h2000,
    parameter logic [15:0] CFG_REG2 = 16'h0400,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        eoc,
    input  logic [4:0]  channel,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [6:0]  drp_daddr,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic [11:0] smp_data,
    output logic [4:0]  smp_chan,
    output logic        smp_dv,
    output logic        smp_ovf,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [6:0]  host_addr,
    input  logic [15:0] host_wdata,
    output logic        host_ack,
    output logic [15:0] host_rdata,
    output logic        host_err,
    output logic        cfg_done,
    output logic        timeout_flag
);

    typedef enum logic [2:0] {CFG_ISSUE, CFG_WAIT, IDLE, SMP_WAIT, HOST_WAIT} state_t;

    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        pend_vld_q, pend_vld_d;
    logic [4:0]  pend_chan_q, pend_chan_d;
    logic [4:0]  rd_chan_q, rd_chan_d;
    logic        den_q, den_d;
    logic        dwe_q, dwe_d;
    logic [6:0]  daddr_q, daddr_d;
    logic [15:0] di_q, di_d;
    logic [11:0] smp_data_q, smp_data_d;
    logic [4:0]  smp_chan_q, smp_chan_d;
    logic        smp_dv_q, smp_dv_d;
    logic        smp_ovf_q, smp_ovf_d;
    logic        host_ack_q, host_ack_d;
    logic [15:0] host_rdata_q, host_rdata_d;
    logic        host_err_q, host_err_d;
    logic        cfg_done_q, cfg_done_d;
    logic        to_flag_q, to_flag_d;

    logic [15:0] cfg_val;
    logic        consume;
    logic        timed_out;

    always_comb begin
        cfg_val = CFG_REG2;
        case (idx_q)
            2'd0:    cfg_val = CFG_REG0;
            2'd1:    cfg_val = CFG_REG1;
            default: cfg_val = CFG_REG2;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        rd_chan_d    = rd_chan_q;
        den_d        = 1'b0;
        dwe_d        = dwe_q;
        daddr_d      = daddr_q;
        di_d         = di_q;
        smp_data_d   = smp_data_q;
        smp_chan_d   = smp_chan_q;
        smp_dv_d     = 1'b0;
        host_ack_d   = 1'b0;
        host_rdata_d = host_rdata_q;
        host_err_d   = 1'b0;
        cfg_done_d   = cfg_done_q;
        to_flag_d    = to_flag_q;
        consume      = 1'b0;
        timed_out    = !drp_drdy && (cnt_q == TO_LAST);

        case (state_q)
            CFG_ISSUE: begin
                den_d   = 1'b1;
                dwe_d   = 1'b1;
                daddr_d = 7'h40 + {5'b0, idx_q};
                di_d    = cfg_val;
                cnt_d   = '0;
                state_d = CFG_WAIT;
            end
            CFG_WAIT: begin
                if (drp_drdy || timed_out) begin
                    if (timed_out) to_flag_d = 1'b1;
                    if (idx_q == 2'd2) begin
                        cfg_done_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = CFG_ISSUE;
                    end
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            IDLE: begin
                // A host grant is held off while an eoc is arriving so the sample wins.
                // host_ack_q blocks re-granting a request the host has not yet dropped.
                if (pend_vld_q) begin
                    consume   = 1'b1;
                    den_d     = 1'b1;
                    dwe_d     = 1'b0;
                    daddr_d   = {2'b00, pend_chan_q};
                    di_d      = '0;
                    rd_chan_d = pend_chan_q;
                    cnt_d     = '0;
                    state_d   = SMP_WAIT;
                end else if (host_req && cfg_done_q && !eoc && !host_ack_q) begin
                    den_d   = 1'b1;
                    dwe_d   = host_we;
                    daddr_d = host_addr;
                    di_d    = host_we ? host_wdata : 16'h0000;
                    cnt_d   = '0;
                    state_d = HOST_WAIT;
                end
            end
            SMP_WAIT: begin
                if (drp_drdy) begin
                    smp_data_d = drp_do[15:4];
                    smp_chan_d = rd_chan_q;
                    smp_dv_d   = 1'b1;
                    state_d    = IDLE;
                end else if (timed_out) begin
                    to_flag_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            HOST_WAIT: begin
                if (drp_drdy) begin
                    host_ack_d   = 1'b1;
                    host_rdata_d = dwe_q ? 16'h0000 : drp_do;
                    state_d      = IDLE;
                end else if (timed_out) begin
                    host_ack_d   = 1'b1;
                    host_err_d   = 1'b1;
                    host_rdata_d = 16'h0000;
                    to_flag_d    = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: state_d = CFG_ISSUE;
        endcase

        pend_vld_d  = pend_vld_q && !consume;
        pend_chan_d = pend_chan_q;
        smp_ovf_d   = eoc && pend_vld_q && !consume;
        if (eoc) begin
            pend_vld_d  = 1'b1;
            pend_chan_d = channel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= CFG_ISSUE;
            idx_q        <= '0;
            cnt_q        <= '0;
            pend_vld_q   <= 1'b0;
            pend_chan_q  <= '0;
            rd_chan_q    <= '0;
            den_q        <= 1'b0;
            dwe_q        <= 1'b0;
            daddr_q      <= '0;
            di_q         <= '0;
            smp_data_q   <= '0;
            smp_chan_q   <= '0;
            smp_dv_q     <= 1'b0;
            smp_ovf_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
            host_err_q   <= 1'b0;
            cfg_done_q   <= 1'b0;
            to_flag_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            pend_vld_q   <= pend_vld_d;
            pend_chan_q  <= pend_chan_d;
            rd_chan_q    <= rd_chan_d;
            den_q        <= den_d;
            dwe_q        <= dwe_d;
            daddr_q      <= daddr_d;
            di_q         <= di_d;
            smp_data_q   <= smp_data_d;
            smp_chan_q   <= smp_chan_d;
            smp_dv_q     <= smp_dv_d;
            smp_ovf_q    <= smp_ovf_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
            host_err_q   <= host_err_d;
            cfg_done_q   <= cfg_done_d;
            to_flag_q    <= to_flag_d;
        end
    end

    assign drp_den      = den_q;
    assign drp_dwe      = dwe_q;
    assign drp_daddr    = daddr_q;
    assign drp_di       = di_q;
    assign smp_data     = smp_data_q;
    assign smp_chan     = smp_chan_q;
    assign smp_dv       = smp_dv_q;
    assign smp_ovf      = smp_ovf_q;
    assign host_ack     = host_ack_q;
    assign host_rdata   = host_rdata_q;
    assign host_err     = host_err_q;
    assign cfg_done     = cfg_done_q;
    assign timeout_flag = to_flag_q;

endmodule

// File: tb/tb_ups_xadc_drp_ctrl.sv
// Bench for ups_xadc_drp_ctrl: a DRP responder with random latency and data, plus event logs compared against expectations derived from the block's rules.
module tb_ups_xadc_drp_ctrl;

    logic        clk, rst, eoc;
    logic [4:0]  channel;
    logic        drp_den, drp_dwe;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di, drp_do;
    logic        drp_drdy;
    logic [11:0] smp_data;
    logic [4:0]  smp_chan;
    logic        smp_dv, smp_ovf;
    logic        host_req, host_we;
    logic [6:0]  host_addr;
    logic [15:0] host_wdata, host_rdata;
    logic        host_ack, host_err, cfg_done, timeout_flag;

    ups_xadc_drp_ctrl dut (
        .clk(clk), .rst(rst), .eoc(eoc), .channel(channel),
        .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
        .drp_do(drp_do), .drp_drdy(drp_drdy),
        .smp_data(smp_data), .smp_chan(smp_chan), .smp_dv(smp_dv), .smp_ovf(smp_ovf),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err),
        .cfg_done(cfg_done), .timeout_flag(timeout_flag)
    );

    typedef struct {
        logic [6:0]  addr;
        logic        dwe;
        logic [15:0] di;
        logic [15:0] rd;
        int          cyc;
    } txn_t;
    typedef struct {
        logic [11:0] data;
        logic [4:0]  chan;
        int          cyc;
    } smp_t;
    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          cyc;
    } ack_t;

    txn_t txn_q[$];
    smp_t smp_q[$];
    ack_t ack_q[$];
    int   ovf_cnt;
    int   cyc;
    int   last_drdy_cyc;
    int   lat;
    bit   suppress;
    bit   resp_busy;
    int   resp_cnt;
    logic [15:0] resp_val;
    int   total, bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // DRP slave model and output monitor, both sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            drp_drdy  = 1'b0;
            resp_busy = 1'b0;
        end else begin
            drp_drdy = 1'b0;
            if (resp_busy) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    drp_drdy      = 1'b1;
                    drp_do        = resp_val;
                    resp_busy     = 1'b0;
                    last_drdy_cyc = cyc;
                end
            end
            if (drp_den) begin
                resp_val = 16'($urandom);
                if (!suppress) begin
                    resp_busy = 1'b1;
                    resp_cnt  = lat;
                end
                txn_q.push_back('{drp_daddr, drp_dwe, drp_di, suppress ? 16'h0 : resp_val, cyc});
            end
        end
        if (smp_dv) smp_q.push_back('{smp_data, smp_chan, cyc});
        if (smp_ovf) ovf_cnt++;
        if (host_ack) ack_q.push_back('{host_rdata, host_err, cyc});
    end

    task automatic clear_logs();
        txn_q.delete();
        smp_q.delete();
        ack_q.delete();
        ovf_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({drp_den, drp_dwe, smp_dv, smp_ovf, host_ack, host_err, cfg_done, timeout_flag} !== 8'h00) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=00000000",
                     {drp_den, drp_dwe, smp_dv, smp_ovf, host_ack, host_err, cfg_done, timeout_flag});
        end
        total++;
        if (drp_daddr !== 7'h00 || drp_di !== 16'h0000) begin
            bad++;
            $display("FAIL reset_drp_bus got addr=%h di=%h exp 00/0000", drp_daddr, drp_di);
        end
        total++;
        if (smp_data !== 12'h000 || smp_chan !== 5'h00 || host_rdata !== 16'h0000) begin
            bad++;
            $display("FAIL reset_data got smp=%h ch=%h rdata=%h exp 0", smp_data, smp_chan, host_rdata);
        end
        clear_logs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_config();
        logic [15:0] exp_cfg [3];
        logic [4:0]  ch;
        int          cfg_cyc;
        exp_cfg = '{16'h0011, 16'h2000, 16'h0400};
        ch  = 5'($urandom_range(0, 31));
        lat = 2;
        @(negedge clk);
        eoc = 1'b1; channel = ch;
        @(negedge clk);
        eoc = 1'b0;
        for (int i = 0; i < 200 && !cfg_done; i++) @(negedge clk);
        cfg_cyc = cyc;
        total++;
        if (cfg_done !== 1'b1) begin
            bad++;
            $display("FAIL cfg_done_rise got=%b exp=1", cfg_done);
        end
        total++;
        if (cfg_cyc != last_drdy_cyc + 1) begin
            bad++;
            $display("FAIL cfg_done_latency got=%0d exp=%0d", cfg_cyc, last_drdy_cyc + 1);
        end
        for (int i = 0; i < 50 && smp_q.size() == 0; i++) @(negedge clk);
        total++;
        if (txn_q.size() != 4 || smp_q.size() != 1) begin
            bad++;
            $display("FAIL cfg_txn_count got txn=%0d smp=%0d exp 4/1", txn_q.size(), smp_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (txn_q[i].addr !== 7'(7'h40 + i) || txn_q[i].dwe !== 1'b1 || txn_q[i].di !== exp_cfg[i]) begin
                    bad++;
                    $display("FAIL cfg_write%0d got addr=%h dwe=%b di=%h exp addr=%h dwe=1 di=%h",
                             i, txn_q[i].addr, txn_q[i].dwe, txn_q[i].di, 7'(7'h40 + i), exp_cfg[i]);
                end
            end
            total++;
            if (txn_q[3].addr !== {2'b00, ch} || txn_q[3].dwe !== 1'b0 ||
                smp_q[0].chan !== ch || smp_q[0].data !== txn_q[3].rd[15:4]) begin
                bad++;
                $display("FAIL cfg_eoc_deferred got addr=%h smp=%h ch=%h exp addr=%h smp=%h ch=%h",
                         txn_q[3].addr, smp_q[0].data, smp_q[0].chan, {2'b00, ch}, txn_q[3].rd[15:4], ch);
            end
        end
    endtask

    task automatic test_sample();
        logic [4:0] ch;
        int         t;
        for (int n = 0; n < 4; n++) begin
            clear_logs();
            ch  = (n == 0) ? 5'h11 : 5'($urandom_range(0, 31));
            lat = $urandom_range(1, 6);
            @(negedge clk);
            eoc = 1'b1; channel = ch; t = cyc;
            @(negedge clk);
            eoc = 1'b0;
            for (int i = 0; i < 40 && smp_q.size() == 0; i++) @(negedge clk);
            total++;
            if (txn_q.size() != 1 || smp_q.size() != 1) begin
                bad++;
                $display("FAIL sample%0d_count got txn=%0d smp=%0d exp 1/1", n, txn_q.size(), smp_q.size());
                continue;
            end
            total++;
            if (txn_q[0].addr !== {2'b00, ch} || txn_q[0].dwe !== 1'b0 || txn_q[0].cyc != t + 2) begin
                bad++;
                $display("FAIL sample%0d_den got addr=%h dwe=%b cyc=%0d exp addr=%h dwe=0 cyc=%0d",
                         n, txn_q[0].addr, txn_q[0].dwe, txn_q[0].cyc, {2'b00, ch}, t + 2);
            end
            total++;
            if (smp_q[0].data !== txn_q[0].rd[15:4] || smp_q[0].chan !== ch || smp_q[0].cyc != last_drdy_cyc + 1) begin
                bad++;
                $display("FAIL sample%0d_result got data=%h ch=%h cyc=%0d exp data=%h ch=%h cyc=%0d",
                         n, smp_q[0].data, smp_q[0].chan, smp_q[0].cyc, txn_q[0].rd[15:4], ch, last_drdy_cyc + 1);
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_host_priority();
        logic [4:0] ch;
        bit         got;
        clear_logs();
        ch  = 5'($urandom_range(1, 31));
        lat = 3;
        @(negedge clk);
        eoc = 1'b1; channel = ch;
        host_req = 1'b1; host_we = 1'b0; host_addr = 7'h00; host_wdata = 16'($urandom);
        @(negedge clk);
        eoc = 1'b0;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (host_ack) begin got = 1; break; end
        end
        host_req = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (!got || txn_q.size() != 2 || ack_q.size() != 1 || smp_q.size() != 1) begin
            bad++;
            $display("FAIL prio_count got ack=%0d txn=%0d acks=%0d smp=%0d exp 1/2/1/1",
                     got, txn_q.size(), ack_q.size(), smp_q.size());
            return;
        end
        total++;
        if (txn_q[0].addr !== {2'b00, ch} || txn_q[0].dwe !== 1'b0 || txn_q[1].addr !== 7'h00 || txn_q[1].dwe !== 1'b0) begin
            bad++;
            $display("FAIL prio_order got first=%h second=%h exp first=%h second=00",
                     txn_q[0].addr, txn_q[1].addr, {2'b00, ch});
        end
        total++;
        if (ack_q[0].rdata !== txn_q[1].rd || ack_q[0].err !== 1'b0) begin
            bad++;
            $display("FAIL prio_host_read got rdata=%h err=%b exp rdata=%h err=0",
                     ack_q[0].rdata, ack_q[0].err, txn_q[1].rd);
        end
    endtask

    task automatic test_host_random();
        logic        we;
        logic [6:0]  addr;
        logic [15:0] wd;
        bit          got;
        for (int n = 0; n < 6; n++) begin
            clear_logs();
            we = 1'($urandom); addr = 7'($urandom); wd = 16'($urandom);
            lat = $urandom_range(1, 8);
            @(negedge clk);
            host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
            got = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (host_ack) begin got = 1; break; end
            end
            host_req = 1'b0;
            repeat (2) @(negedge clk);
            total++;
            if (!got || txn_q.size() != 1 || ack_q.size() != 1) begin
                bad++;
                $display("FAIL host%0d_count got ack=%0d txn=%0d acks=%0d exp 1/1/1", n, got, txn_q.size(), ack_q.size());
                continue;
            end
            total++;
            if (txn_q[0].addr !== addr || txn_q[0].dwe !== we || (we && txn_q[0].di !== wd)) begin
                bad++;
                $display("FAIL host%0d_drp got addr=%h dwe=%b di=%h exp addr=%h dwe=%b di=%h",
                         n, txn_q[0].addr, txn_q[0].dwe, txn_q[0].di, addr, we, wd);
            end
            total++;
            if (ack_q[0].rdata !== (we ? 16'h0000 : txn_q[0].rd) || ack_q[0].err !== 1'b0 ||
                ack_q[0].cyc != last_drdy_cyc + 1) begin
                bad++;
                $display("FAIL host%0d_ack got rdata=%h err=%b cyc=%0d exp rdata=%h err=0 cyc=%0d",
                         n, ack_q[0].rdata, ack_q[0].err, ack_q[0].cyc, we ? 16'h0000 : txn_q[0].rd, last_drdy_cyc + 1);
            end
        end
        total++;
        if (timeout_flag !== 1'b0) begin
            bad++;
            $display("FAIL no_spurious_timeout got=%b exp=0", timeout_flag);
        end
    endtask

    task automatic test_ovf();
        bit got;
        clear_logs();
        lat = 20;
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b1; host_addr = 7'h45; host_wdata = 16'($urandom);
        repeat (3) @(negedge clk);
        eoc = 1'b1; channel = 5'h01;
        @(negedge clk);
        channel = 5'h02;
        @(negedge clk);
        eoc = 1'b0;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (host_ack) begin got = 1; break; end
        end
        host_req = 1'b0;
        repeat (40) @(negedge clk);
        total++;
        if (ovf_cnt != 1) begin
            bad++;
            $display("FAIL ovf_pulses got=%0d exp=1", ovf_cnt);
        end
        total++;
        if (!got || txn_q.size() != 2 || smp_q.size() != 1) begin
            bad++;
            $display("FAIL ovf_count got ack=%0d txn=%0d smp=%0d exp 1/2/1", got, txn_q.size(), smp_q.size());
        end else if (txn_q[1].addr !== 7'h02 || txn_q[1].dwe !== 1'b0 || smp_q[0].chan !== 5'h02) begin
            bad++;
            $display("FAIL ovf_survivor got addr=%h ch=%h exp addr=02 ch=02", txn_q[1].addr, smp_q[0].chan);
        end
        lat = 2;
    endtask

    task automatic test_timeout();
        bit got;
        clear_logs();
        suppress = 1'b1;
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b1; host_addr = 7'($urandom); host_wdata = 16'($urandom);
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (host_ack) begin got = 1; break; end
        end
        host_req = 1'b0;
        @(negedge clk);
        total++;
        if (!got || txn_q.size() != 1 || ack_q.size() != 1) begin
            bad++;
            $display("FAIL timeout_count got ack=%0d txn=%0d acks=%0d exp 1/1/1", got, txn_q.size(), ack_q.size());
        end else begin
            total++;
            if (ack_q[0].cyc - txn_q[0].cyc != 64 || ack_q[0].err !== 1'b1 || ack_q[0].rdata !== 16'h0000) begin
                bad++;
                $display("FAIL timeout_ack got delay=%0d err=%b rdata=%h exp delay=64 err=1 rdata=0000",
                         ack_q[0].cyc - txn_q[0].cyc, ack_q[0].err, ack_q[0].rdata);
            end
        end
        clear_logs();
        eoc = 1'b1; channel = 5'($urandom);
        @(negedge clk);
        eoc = 1'b0;
        repeat (90) @(negedge clk);
        total++;
        if (txn_q.size() != 1 || smp_q.size() != 0) begin
            bad++;
            $display("FAIL sample_timeout got txn=%0d smp=%0d exp 1/0", txn_q.size(), smp_q.size());
        end
        total++;
        if (timeout_flag !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky got=%b exp=1", timeout_flag);
        end
        suppress = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit hit;
        lat = 5;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        clear_logs();
        rst = 1'b0;
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (drp_den && drp_daddr == 7'h41) begin hit = 1; break; end
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (!hit || drp_daddr !== 7'h00 || drp_dwe !== 1'b0 || drp_di !== 16'h0000 ||
            drp_den !== 1'b0 || timeout_flag !== 1'b0 || cfg_done !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got hit=%0d addr=%h dwe=%b di=%h den=%b tflag=%b done=%b exp all 0",
                     hit, drp_daddr, drp_dwe, drp_di, drp_den, timeout_flag, cfg_done);
        end
        @(negedge clk);
        clear_logs();
        rst = 1'b0;
        for (int i = 0; i < 200 && !cfg_done; i++) @(negedge clk);
        @(negedge clk);
        total++;
        if (txn_q.size() != 3 || txn_q[0].addr !== 7'h40 || txn_q[1].addr !== 7'h41 || txn_q[2].addr !== 7'h42 || cfg_done !== 1'b1) begin
            bad++;
            $display("FAIL reset_replay got n=%0d first=%h done=%b exp n=3 first=40 done=1",
                     txn_q.size(), (txn_q.size() > 0) ? txn_q[0].addr : 7'h7f, cfg_done);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0; cyc = 0; last_drdy_cyc = 0;
        lat = 2; suppress = 1'b0; resp_busy = 1'b0; resp_cnt = 0; resp_val = '0;
        rst = 1'b1; eoc = 1'b0; channel = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        drp_do = '0; drp_drdy = 1'b0; ovf_cnt = 0;
        test_reset();
        test_config();
        test_sample();
        test_host_priority();
        test_host_random();
        test_ovf();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
